// File: rtl/serial_tx_port.sv
// Byte FIFO feeding a UART-style serialiser: 8N1 frames, or 8E1 when SERIAL_TX_PARITY_EN is defined.
// Dout is registered, so it trails the FSM state by one clock; a push into an idle port reaches the line two edges later.
module serial_tx_port #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       WrEn,
  input  logic [7:0] WrData,
  output logic       Full,
  output logic       Busy,
  output logic       Overflow,
  output logic       Dout
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_nempty;

  // Transmitter
  state_t           state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             dout_q, dout_d;
  logic             baud_end;

  assign Full        = (count_q == CNT_FULL);
  assign fifo_nempty = (count_q != '0);
  assign fifo_push   = WrEn && !Full;
  assign baud_end    = (baud_q == BAUD_LAST);

  assign Busy     = (state_q != ST_IDLE) || fifo_nempty;
  assign Overflow = overflow_q;
  assign Dout     = dout_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // A rejected push flags overflow even when a pop frees a slot this cycle.
    if (WrEn && Full) begin
      overflow_d = 1'b1;
    end

    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    dout_d   = 1'b1;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dout_d = 1'b1;
        if (fifo_nempty) begin
          fifo_pop = 1'b1;
          data_d   = mem_q[rd_ptr_q];
          baud_d   = '0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        dout_d = 1'b0;
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        dout_d = data_q[bit_q];
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        dout_d = ^data_q;
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        dout_d = 1'b1;
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames abut with no idle gap.
          if (fifo_nempty) begin
            fifo_pop = 1'b1;
            data_d   = mem_q[rd_ptr_q];
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= WrData;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      dout_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      dout_q     <= dout_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_port.sv
// Directed bench for serial_tx_port: a line decoder checks every frame against a queue of expected bytes.
module tb_serial_tx_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       WrEn;
  logic [7:0] WrData;
  logic       Full;
  logic       Busy;
  logic       Overflow;
  logic       Dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reset_cnt = 0;
  int frames = 0;
  int aborts = 0;
  int start_cyc [64];
  logic last_par = 1'b0;
  logic [7:0] exp_q [$];

  serial_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrData(WrData),
    .Full(Full), .Busy(Busy), .Overflow(Overflow), .Dout(Dout)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (Reset === 1'b0) reset_cnt <= reset_cnt + 1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decodes one frame whose start bit was seen at the current falling edge.
  task automatic decode();
    logic [7:0] b;
    logic [8:0] exp;
    int rc;
    rc = reset_cnt;
    if (frames < 64) start_cyc[frames] = cyc;
    repeat (CPB / 2) @(negedge Clock);
    if (reset_cnt != rc) begin
      aborts++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    chk("start_bit", {31'd0, Dout}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge Clock);
      if (reset_cnt != rc) begin
        aborts++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        return;
      end
      b[i] = Dout;
    end
`ifdef SERIAL_TX_PARITY_EN
    repeat (CPB) @(negedge Clock);
    last_par = Dout;
    chk("parity_bit", {31'd0, Dout}, {31'd0, ^b});
`endif
    repeat (CPB) @(negedge Clock);
    chk("stop_bit", {31'd0, Dout}, 32'd1);
    exp = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h1FF;
    chk("rx_byte", {24'd0, b}, {23'd0, exp});
    frames++;
  endtask

  initial begin : monitor
    forever begin
      @(negedge Clock);
      if (Reset === 1'b1 && Dout === 1'b0) decode();
    end
  end

  task automatic push(input logic [7:0] b, input bit accept);
    WrEn   = 1'b1;
    WrData = b;
    if (accept) exp_q.push_back(b);
    @(negedge Clock);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames < n && k < budget) begin
      @(negedge Clock);
      k++;
    end
    chk("frames_done", {31'd0, frames >= n}, 32'd1);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_dout"}, {31'd0, Dout}, 32'd1);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_full"}, {31'd0, Full}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, Overflow}, 32'd0);
  endtask

  initial begin : stim
    int n;
    int f0;
    Reset  = 1'b0;
    WrEn   = 1'b0;
    WrData = 8'h00;

    // Reset and quiet idle
    repeat (2) @(negedge Clock);
    idle_checks("reset");
    Reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      idle_checks("idle");
    end

    // Single frame, latency and Busy release
    f0 = frames;
    push(8'hA5, 1'b1);
    n = cyc;
    WrEn = 1'b0;
    repeat (FRAME_CYC) @(negedge Clock);
    chk("busy_last_cycle", {31'd0, Busy}, 32'd1);
    @(negedge Clock);
    chk("busy_released", {31'd0, Busy}, 32'd0);
    wait_frames(f0 + 1, 200);
    chk("start_latency", start_cyc[f0] - n, 32'd2);
    repeat (10) @(negedge Clock);

    // Three back-to-back frames
    f0 = frames;
    push(8'h01, 1'b1);
    n = cyc;
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    WrEn = 1'b0;
    wait_frames(f0 + 3, 600);
    chk("b2b_gap1", start_cyc[f0 + 1] - start_cyc[f0], FRAME_CYC);
    chk("b2b_gap2", start_cyc[f0 + 2] - start_cyc[f0 + 1], FRAME_CYC);
    while (cyc < n + 3 * FRAME_CYC) @(negedge Clock);
    chk("b2b_busy_end", {31'd0, Busy}, 32'd1);
    @(negedge Clock);
    chk("b2b_idle", {31'd0, Busy}, 32'd0);
    chk("b2b_queue_empty", exp_q.size(), 32'd0);
    repeat (10) @(negedge Clock);

    // Overflow: six pushes, first one drains at once, sixth dropped
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i), i < 5);
      chk("fill_full", {31'd0, Full}, {31'd0, i >= 4});
      chk("fill_ovf", {31'd0, Overflow}, {31'd0, i == 5});
    end
    WrEn = 1'b0;
    wait_frames(f0 + 5, 1200);
    repeat (3 * FRAME_CYC) @(negedge Clock);
    chk("ovf_frame_count", frames - f0, 32'd5);
    chk("ovf_sticky", {31'd0, Overflow}, 32'd1);
    chk("ovf_queue_empty", exp_q.size(), 32'd0);
    chk("ovf_idle", {31'd0, Busy}, 32'd0);

    // Reset in the middle of data bit 3
    f0 = frames;
    push(8'h5A, 1'b1);
    n = cyc;
    WrEn = 1'b0;
    while (cyc < n + 18) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    idle_checks("midreset");
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (i % 10 == 0) chk("post_reset_dout", {31'd0, Dout}, 32'd1);
    end
    chk("post_reset_frames", frames - f0, 32'd0);
    chk("post_reset_abort", aborts, 32'd1);
    chk("post_reset_busy", {31'd0, Busy}, 32'd0);

`ifdef SERIAL_TX_PARITY_EN
    // Even parity over the data byte
    f0 = frames;
    push(8'h07, 1'b1);
    WrEn = 1'b0;
    wait_frames(f0 + 1, 200);
    chk("parity_07", {31'd0, last_par}, 32'd1);
    push(8'h03, 1'b1);
    WrEn = 1'b0;
    wait_frames(f0 + 2, 200);
    chk("parity_03", {31'd0, last_par}, 32'd0);
`endif

    repeat (20) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
